// File: rtl/count_compare_if.sv
// Wishbone classic-cycle slave bus bundle for count_compare.
//   master modport : drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave modport  : the reverse; used by count_compare itself
interface count_compare_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/count_compare.sv
// count_compare: compare / capture unit watching an external free-running count.
//   wb_clk_i   : clock, all state changes on rising edge
//   wb_rst_ni  : async active-low reset
//   wb         : Wishbone slave (CTRL @0x0, CMP @0x4, CAP @0x8 ro, STATUS @0xC w1c)
//   count_i    : upstream count value
//   cap_i      : asynchronous capture pin
//   irq_o      : level interrupt, (match_f & ie_match) | (cap_f & ie_cap)
module count_compare #(
  parameter int BITS = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  count_compare_if.slave  wb,
  input  logic [BITS-1:0] count_i,
  input  logic            cap_i,
  output logic            irq_o
);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_CMP  = 2'd1;
  localparam logic [1:0] A_CAP  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  // ctrl_q: [0] cmp_en [1] cap_en [2] cap_edge [3] ie_match [4] ie_cap
  logic [4:0]      ctrl_q;
  logic [BITS-1:0] cmp_q;
  logic [BITS-1:0] cap_q;
  logic            match_f;
  logic            cap_f;
  logic            ovr_f;
  logic            eq_q;
  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect flop
  logic [2:0]      sync_q;

  logic            valid;
  logic            access;
  logic            wr;
  logic [1:0]      addr;
  logic            eq_now;
  logic            match_ev;
  logic            cap_ev;
  logic [2:0]      stat_clr;
  logic [BITS-1:0] cmp_nxt;
  logic [31:0]     rd_mux;
  logic            unused_bits;

  assign valid  = wb.wbs_cyc_i & wb.wbs_stb_i;
  // ack low is part of the qualifier so each transfer acks once and
  // back-to-back cycles are spaced at least two clocks apart
  assign access = valid & ~wb.wbs_ack_o;
  assign wr     = access & wb.wbs_we_i;
  assign addr   = wb.wbs_adr_i[3:2];

  // match only on entry into equality so a stalled count cannot re-fire
  assign eq_now   = (count_i == cmp_q);
  assign match_ev = ctrl_q[0] & eq_now & ~eq_q;

  assign cap_ev = ctrl_q[1] &
                  (ctrl_q[2] ? (~sync_q[1] &  sync_q[2])
                             : ( sync_q[1] & ~sync_q[2]));

  assign stat_clr = (wr && addr == A_STAT && wb.wbs_sel_i[0]) ?
                    wb.wbs_dat_i[2:0] : 3'b000;

  always_comb begin
    cmp_nxt = cmp_q;
    for (int i = 0; i < BITS; i++) begin
      if (wb.wbs_sel_i[i/8]) cmp_nxt[i] = wb.wbs_dat_i[i];
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (addr)
      A_CTRL: rd_mux = {27'h0, ctrl_q};
      A_CMP:  rd_mux = 32'(cmp_q);
      A_CAP:  rd_mux = 32'(cap_q);
      A_STAT: rd_mux = {29'h0, ovr_f, cap_f, match_f};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_q       <= '0;
      cmp_q        <= '0;
      cap_q        <= '0;
      match_f      <= 1'b0;
      cap_f        <= 1'b0;
      ovr_f        <= 1'b0;
      eq_q         <= 1'b0;
      sync_q       <= '0;
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= access;
      if (access) wb.wbs_dat_o <= rd_mux;

      if (wr && addr == A_CTRL && wb.wbs_sel_i[0]) ctrl_q <= wb.wbs_dat_i[4:0];
      if (wr && addr == A_CMP) cmp_q <= cmp_nxt;

      eq_q   <= eq_now;
      sync_q <= {sync_q[1:0], cap_i};

      if (cap_ev) cap_q <= count_i;

      // events are OR-ed in after the w1c clear so a same-clock event wins;
      // overrun looks at cap_f before this edge's clear
      match_f <= (match_f & ~stat_clr[0]) | match_ev;
      cap_f   <= (cap_f   & ~stat_clr[1]) | cap_ev;
      ovr_f   <= (ovr_f   & ~stat_clr[2]) | (cap_ev & cap_f);
    end
  end

  assign irq_o = (match_f & ctrl_q[3]) | (cap_f & ctrl_q[4]);

  assign unused_bits = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0],
                         wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:16]};

endmodule

// File: tb/tb_count_compare.sv
// Self-checking bench for count_compare: directed scenarios plus random
// traffic, all checked against a register-level reference model.
module tb_count_compare;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] count;
  logic        cap;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  count_compare_if wb_bus ();

  count_compare #(.BITS(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (wb_bus.slave),
    .count_i  (count),
    .cap_i    (cap),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [4:0]  m_ctrl;
  logic [15:0] m_cmp;
  logic [15:0] m_cap;
  logic        m_mf, m_cf, m_of;
  logic        m_was_equal;     // count equalled CMP at the previous edge
  logic        m_seen [3];      // cap_i as sampled 1, 2, 3 edges ago
  logic        m_ack;
  logic [31:0] m_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_cmp = '0; m_cap = '0;
    m_mf = 0; m_cf = 0; m_of = 0;
    m_was_equal = 0;
    m_seen[0] = 0; m_seen[1] = 0; m_seen[2] = 0;
    m_ack = 0; m_dat = '0;
  endtask

  function automatic logic m_irq();
    return (m_mf && m_ctrl[3]) || (m_cf && m_ctrl[4]);
  endfunction

  // advance the model by one rising edge using the inputs now applied
  task automatic model_edge();
    logic        equal, mev, cev, acc;
    logic [2:0]  clr;
    logic [1:0]  a;
    equal = (count == m_cmp);
    mev   = m_ctrl[0] && equal && !m_was_equal;
    m_was_equal = equal;
    // a transition becomes an event once it is two edges deep in history
    if (m_ctrl[2]) cev = m_ctrl[1] && m_seen[2] && !m_seen[1];
    else           cev = m_ctrl[1] && !m_seen[2] && m_seen[1];
    m_seen[2] = m_seen[1]; m_seen[1] = m_seen[0]; m_seen[0] = cap;

    clr = 3'b000;
    a   = wb_bus.wbs_adr_i[3:2];
    acc = wb_bus.wbs_cyc_i && wb_bus.wbs_stb_i && !m_ack;
    if (acc) begin
      case (a)
        2'd0: m_dat = {27'h0, m_ctrl};
        2'd1: m_dat = {16'h0, m_cmp};
        2'd2: m_dat = {16'h0, m_cap};
        default: m_dat = {29'h0, m_of, m_cf, m_mf};
      endcase
      if (wb_bus.wbs_we_i) begin
        if (a == 2'd0 && wb_bus.wbs_sel_i[0]) m_ctrl = wb_bus.wbs_dat_i[4:0];
        if (a == 2'd1) begin
          if (wb_bus.wbs_sel_i[0]) m_cmp[7:0]  = wb_bus.wbs_dat_i[7:0];
          if (wb_bus.wbs_sel_i[1]) m_cmp[15:8] = wb_bus.wbs_dat_i[15:8];
        end
        if (a == 2'd3 && wb_bus.wbs_sel_i[0]) clr = wb_bus.wbs_dat_i[2:0];
      end
    end
    m_ack = acc;

    m_of = (m_of && !clr[2]) || (cev && m_cf);
    m_cf = (m_cf && !clr[1]) || cev;
    m_mf = (m_mf && !clr[0]) || mev;
    if (cev) m_cap = count;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("ack",   {31'h0, wb_bus.wbs_ack_o}, {31'h0, m_ack});
    chk("irq",   {31'h0, irq},              {31'h0, m_irq()});
    chk("rdata", wb_bus.wbs_dat_o,          m_dat);
  endtask

  task automatic wb_access(input logic we, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
    wb_bus.wbs_cyc_i = 1'b1;
    wb_bus.wbs_stb_i = 1'b1;
    wb_bus.wbs_we_i  = we;
    wb_bus.wbs_adr_i = ($urandom & 32'hFFFF_FFF0) | {28'h0, a, 2'b00} | ($urandom & 32'h3);
    wb_bus.wbs_dat_i = d;
    wb_bus.wbs_sel_i = sel;
    step();
    chk("ack_hi", {31'h0, wb_bus.wbs_ack_o}, 32'h1);
    rd = wb_bus.wbs_dat_o;
    wb_bus.wbs_cyc_i = 1'b0;
    wb_bus.wbs_stb_i = 1'b0;
    wb_bus.wbs_we_i  = 1'b0;
    step();
    chk("ack_lo", {31'h0, wb_bus.wbs_ack_o}, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] junk;
    wb_access(1'b1, a, d, sel, junk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    wb_access(1'b0, a, $urandom, 4'hF, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst_n = 1'b0;
    count = '0;
    cap   = 1'b0;
    wb_bus.wbs_cyc_i = 0; wb_bus.wbs_stb_i = 0; wb_bus.wbs_we_i = 0;
    wb_bus.wbs_sel_i = '0; wb_bus.wbs_dat_i = '0; wb_bus.wbs_adr_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'h0, wb_bus.wbs_ack_o}, 32'h0);
    chk("rst_dat", wb_bus.wbs_dat_o, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    #2 rst_n = 1'b1;

    // compare match with a ramping count
    wr(2'd0, 32'h09, 4'hF);
    wr(2'd1, 32'h0010, 4'hF);
    for (int i = 0; i <= 16; i++) begin
      count = 16'(i);
      step();
    end
    chk("match_irq", {31'h0, irq}, 32'h1);
    repeat (5) step();
    rd(2'd3, v);
    chk("match_status", v, 32'h1);
    wr(2'd3, 32'h1, 4'h1);
    repeat (3) step();
    chk("no_retrigger_irq", {31'h0, irq}, 32'h0);
    rd(2'd3, v);
    chk("no_retrigger_status", v, 32'h0);

    // rising-edge capture, then overrun
    wr(2'd0, 32'h12, 4'hF);
    count = 16'h1234;
    cap   = 1'b1;
    repeat (3) step();
    chk("cap_irq", {31'h0, irq}, 32'h1);
    rd(2'd2, v);
    chk("cap_val1", v, 32'h1234);
    rd(2'd3, v);
    chk("cap_status1", v, 32'h2);
    cap = 1'b0;
    repeat (4) step();
    count = 16'h2000;
    cap   = 1'b1;
    repeat (3) step();
    rd(2'd2, v);
    chk("cap_val2", v, 32'h2000);
    rd(2'd3, v);
    chk("ovr_status", v, 32'h6);

    // w1c of cap_f on the same edge as a capture event
    wr(2'd3, 32'h7, 4'h1);
    rd(2'd3, v);
    chk("status_cleared", v, 32'h0);
    cap = 1'b0;
    repeat (4) step();
    cap = 1'b1;
    repeat (2) step();
    wr(2'd3, 32'h2, 4'h1);
    rd(2'd3, v);
    chk("event_beats_w1c", v & 32'h2, 32'h2);

    // byte-lane write of CMP
    wr(2'd1, 32'h0055, 4'hF);
    wr(2'd1, 32'hAB00, 4'h2);
    rd(2'd1, v);
    chk("cmp_bytelane", v, 32'hAB55);
    wr(2'd2, 32'hFFFF, 4'hF);
    rd(2'd2, v);
    chk("cap_readonly", v, 32'h2000);

    // reset in the middle of a bus cycle with a flag pending
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    wb_bus.wbs_cyc_i = 1; wb_bus.wbs_stb_i = 1; wb_bus.wbs_we_i = 1;
    wb_bus.wbs_adr_i = 32'h0; wb_bus.wbs_dat_i = 32'h1F; wb_bus.wbs_sel_i = 4'hF;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ack", {31'h0, wb_bus.wbs_ack_o}, 32'h0);
    chk("midrst_dat", wb_bus.wbs_dat_o, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    wb_bus.wbs_cyc_i = 0; wb_bus.wbs_stb_i = 0; wb_bus.wbs_we_i = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("abort_noack", {31'h0, wb_bus.wbs_ack_o}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("post_rst_reg", v, 32'h0);
    end
    chk("post_rst_irq", {31'h0, irq}, 32'h0);

    // random traffic against the model
    count = '0;
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        logic [1:0]  a;
        logic [31:0] d;
        a = 2'($urandom_range(0, 3));
        d = (a == 2'd3) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 31));
        wb_access(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), v);
      end else begin
        case ($urandom_range(0, 3))
          0, 1: count = count + 16'd1;
          2:    count = count;
          default: count = 16'($urandom_range(0, 31));
        endcase
        if (count > 16'd31) count = '0;
        if ($urandom_range(0, 3) == 0) cap = ~cap;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
